// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, stall FSM encoding and a register-match helper.
// Combinational only. No backpressure.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } stall_state_e;

    typedef logic [1:0] need_t;

    // $0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] src, input logic srcRead,
                                      input logic [4:0] dst);
        return srcRead && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/di_hazard_detect.sv
// Decode-stage source matching; reports how many stall cycles the ID instruction needs (0..2).
// Zero latency, purely combinational. No backpressure.
module di_hazard_detect
    import mips_pkg::*;
#(
    parameter logic [5:0] BEQ_OP   = OP_BEQ,
    parameter logic [5:0] SW_OP    = OP_SW,
    parameter logic [5:0] RTYPE_OP = OP_RTYPE
) (
    input  logic [5:0] IFIDopcode,
    input  logic [4:0] IFIDrs,
    input  logic [4:0] IFIDrt,
    input  logic       IDEXregwrite,
    input  logic       IDEXmemread,
    input  logic [4:0] IDEXWriteReg,
    input  logic       EXMEregwrite,
    input  logic       EXMEmemtoreg,
    input  logic [4:0] EXMEWriteReg,
    output need_t      need
);

    logic rsRead;
    logic rtRead;
    logic isBeq;
    logic exHit;
    logic meHit;
    logic loadUse;
    logic branchAlu;
    logic branchLate;

    always_comb begin
        rsRead = !((IFIDopcode == OP_J) || (IFIDopcode == OP_JAL));
        rtRead = (IFIDopcode == RTYPE_OP) || (IFIDopcode == SW_OP) || (IFIDopcode == BEQ_OP);
        isBeq  = (IFIDopcode == BEQ_OP);

        exHit = regMatch(IFIDrs, rsRead, IDEXWriteReg) || regMatch(IFIDrt, rtRead, IDEXWriteReg);
        meHit = regMatch(IFIDrs, rsRead, EXMEWriteReg) || regMatch(IFIDrt, rtRead, EXMEWriteReg);

        loadUse    = IDEXmemread && IDEXregwrite && exHit;
        branchAlu  = isBeq && IDEXregwrite && !IDEXmemread && exHit;
        branchLate = isBeq && EXMEregwrite && EXMEmemtoreg && meHit;

        // Priority encodes the maximum of the individual needs, never their sum.
        need = 2'd0;
        if (branchAlu || branchLate) begin
            need = 2'd1;
        end
        if (loadUse) begin
            need = isBeq ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: rtl/di_hazard_stall_unit.sv
// Decode hazard stall unit: freezes PC and IF/ID and bubbles ID/EX for 1 or 2 cycles per hazard.
// Zero-cycle detection (Mealy outputs); the second stall of a 2-cycle hazard comes from HOLD state.
// No backpressure; the stall outputs are themselves the pipeline backpressure.
module di_hazard_stall_unit
    import mips_pkg::*;
#(
    parameter logic [5:0] BEQ_OP   = OP_BEQ,
    parameter logic [5:0] LW_OP    = OP_LW,
    parameter logic [5:0] SW_OP    = OP_SW,
    parameter logic [5:0] RTYPE_OP = OP_RTYPE,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       IFIDopcode,
    input  logic [4:0]       IFIDrs,
    input  logic [4:0]       IFIDrt,
    input  logic             IDEXregwrite,
    input  logic             IDEXmemread,
    input  logic [4:0]       IDEXWriteReg,
    input  logic             EXMEregwrite,
    input  logic             EXMEmemtoreg,
    input  logic [4:0]       EXMEWriteReg,
    output logic             pcWrite,
    output logic             IFIDwrite,
    output logic             IDEXbubble,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic [5:0] LOAD_OP = LW_OP;

    stall_state_e state;
    stall_state_e nextState;
    need_t        need;
    logic         stall;
    logic         loadOpSeen;

    di_hazard_detect #(
        .BEQ_OP   (BEQ_OP),
        .SW_OP    (SW_OP),
        .RTYPE_OP (RTYPE_OP)
    ) uDetect (
        .IFIDopcode   (IFIDopcode),
        .IFIDrs       (IFIDrs),
        .IFIDrt       (IFIDrt),
        .IDEXregwrite (IDEXregwrite),
        .IDEXmemread  (IDEXmemread),
        .IDEXWriteReg (IDEXWriteReg),
        .EXMEregwrite (EXMEregwrite),
        .EXMEmemtoreg (EXMEmemtoreg),
        .EXMEWriteReg (EXMEWriteReg),
        .need         (need)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // HOLD is the committed second stall of a beq-after-load; inputs are ignored there.
    always_comb begin
        nextState  = RUN;
        stall      = 1'b0;
        loadOpSeen = (IFIDopcode == LOAD_OP);
        unique case (state)
            RUN: begin
                stall = (need != 2'd0);
                if (need == 2'd2) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                stall = 1'b1;
            end
            default: begin
                nextState = RUN;
            end
        endcase
        pcWrite    = !stall;
        IFIDwrite  = !stall;
        IDEXbubble = stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

    logic unusedOk;
    assign unusedOk = loadOpSeen;

endmodule

// File: tb/tb_di_hazard_stall_unit.sv
// Directed bench for di_hazard_stall_unit: stimulus pushes expectations, a negedge monitor pops and checks.
module tb_di_hazard_stall_unit;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  IFIDopcode = '0;
    logic [4:0]  IFIDrs = '0;
    logic [4:0]  IFIDrt = '0;
    logic        IDEXregwrite = 1'b0;
    logic        IDEXmemread = 1'b0;
    logic [4:0]  IDEXWriteReg = '0;
    logic        EXMEregwrite = 1'b0;
    logic        EXMEmemtoreg = 1'b0;
    logic [4:0]  EXMEWriteReg = '0;

    logic        pcWrite, IFIDwrite, IDEXbubble;
    logic [15:0] stallCount;
    logic        sPcWrite, sIFIDwrite, sIDEXbubble;
    logic [2:0]  sStallCount;

    int tests = 0;
    int fails = 0;
    int cnt = 0;
    int cntSat = 0;

    typedef struct {
        logic stall;
        int   cnt;
        int   cntSat;
        int   id;
    } exp_t;
    exp_t expQ[$];

    always #5 clk = ~clk;

    di_hazard_stall_unit dut (
        .clk(clk), .reset(reset),
        .IFIDopcode(IFIDopcode), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt),
        .IDEXregwrite(IDEXregwrite), .IDEXmemread(IDEXmemread), .IDEXWriteReg(IDEXWriteReg),
        .EXMEregwrite(EXMEregwrite), .EXMEmemtoreg(EXMEmemtoreg), .EXMEWriteReg(EXMEWriteReg),
        .pcWrite(pcWrite), .IFIDwrite(IFIDwrite), .IDEXbubble(IDEXbubble),
        .stallCount(stallCount)
    );

    di_hazard_stall_unit #(.CNT_W(3)) dutSat (
        .clk(clk), .reset(reset),
        .IFIDopcode(IFIDopcode), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt),
        .IDEXregwrite(IDEXregwrite), .IDEXmemread(IDEXmemread), .IDEXWriteReg(IDEXWriteReg),
        .EXMEregwrite(EXMEregwrite), .EXMEmemtoreg(EXMEmemtoreg), .EXMEWriteReg(EXMEWriteReg),
        .pcWrite(sPcWrite), .IFIDwrite(sIFIDwrite), .IDEXbubble(sIDEXbubble),
        .stallCount(sStallCount)
    );

    task automatic check(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic checkAll(input string tag, input logic st, input int c, input int cs);
        check({tag, " pcWrite"}, int'(pcWrite), int'(!st));
        check({tag, " IFIDwrite"}, int'(IFIDwrite), int'(!st));
        check({tag, " IDEXbubble"}, int'(IDEXbubble), int'(st));
        check({tag, " stallCount"}, int'(stallCount), c);
        check({tag, " sat stall"}, int'(sIDEXbubble & ~sPcWrite & ~sIFIDwrite), int'(st));
        check({tag, " sat stallCount"}, int'(sStallCount), cs);
    endtask

    // One vector per cycle: driven just after posedge, checked by the monitor at negedge.
    task automatic step(input int id, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic exRw, input logic exMr, input logic [4:0] exWr,
                        input logic meRw, input logic meMtr, input logic [4:0] meWr,
                        input logic expStall);
        exp_t e;
        @(posedge clk);
        #1;
        IFIDopcode = op; IFIDrs = rs; IFIDrt = rt;
        IDEXregwrite = exRw; IDEXmemread = exMr; IDEXWriteReg = exWr;
        EXMEregwrite = meRw; EXMEmemtoreg = meMtr; EXMEWriteReg = meWr;
        e.stall = expStall; e.cnt = cnt; e.cntSat = cntSat; e.id = id;
        expQ.push_back(e);
        if (expStall && !reset) begin
            if (cnt < 65535) cnt++;
            if (cntSat < 7) cntSat++;
        end
    endtask

    task automatic idle(input int id, input logic expStall);
        step(id, RT, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, expStall);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkAll($sformatf("vec%0d", e.id), e.stall, e.cnt, e.cntSat);
            end
        end
    end

    initial begin : stim
        // reset state
        idle(0, 1'b0);
        idle(1, 1'b0);
        @(posedge clk); #2; reset = 1'b0;

        // load-use, R-type rs=5: one stall
        step(10, RT, 5'd5, 5'd0, 1, 1, 5'd5, 0, 0, 5'd0, 1'b1);
        idle(11, 1'b0);
        // load then beq rs=5 rt=9: RUN->HOLD->RUN, two stalls
        step(20, BEQ, 5'd5, 5'd9, 1, 1, 5'd5, 0, 0, 5'd0, 1'b1);
        idle(21, 1'b1);
        idle(22, 1'b0);
        // beq rs=rt=3 vs ALU write to 3: one stall only
        step(30, BEQ, 5'd3, 5'd3, 1, 0, 5'd3, 0, 0, 5'd0, 1'b1);
        idle(31, 1'b0);
        // register 0 and j never hazard
        step(40, RT, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 1'b0);
        step(41, J, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 1'b0);
        // branch vs load in MEM
        step(50, BEQ, 5'd1, 5'd7, 0, 0, 5'd0, 1, 1, 5'd7, 1'b1);
        step(51, BEQ, 5'd1, 5'd7, 0, 0, 5'd0, 1, 0, 5'd7, 1'b0);
        // rt read only for R-type/sw/beq
        step(60, LW, 5'd2, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 1'b0);
        step(61, SW, 5'd2, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 1'b1);
        // ALU result feeding non-branch is forwarded, no stall
        step(70, RT, 5'd4, 5'd0, 1, 0, 5'd4, 0, 0, 5'd0, 1'b0);
        // memread without regwrite is not a load-use
        step(71, RT, 5'd4, 5'd0, 0, 1, 5'd4, 0, 0, 5'd0, 1'b0);
        // combined load-use(2) and branch-late(1): max=2; HOLD ignores held inputs
        step(80, BEQ, 5'd5, 5'd6, 1, 1, 5'd5, 1, 1, 5'd6, 1'b1);
        step(81, BEQ, 5'd5, 5'd6, 1, 1, 5'd5, 1, 1, 5'd6, 1'b1);
        idle(82, 1'b0);

        // async reset in the middle of HOLD
        step(90, BEQ, 5'd5, 5'd9, 1, 1, 5'd5, 0, 0, 5'd0, 1'b1);
        @(posedge clk); #1;
        IFIDopcode = RT; IFIDrs = 0; IFIDrt = 0; IDEXregwrite = 0; IDEXmemread = 0; IDEXWriteReg = 0;
        #1;
        checkAll("hold before reset", 1'b1, cnt, cntSat);
        reset = 1'b1;
        #1;
        cnt = 0; cntSat = 0;
        checkAll("async reset", 1'b0, 0, 0);
        @(posedge clk); #2; reset = 1'b0;
        idle(91, 1'b0);

        // saturation on the 3-bit instance: 6 -> 7, then stays 7
        for (int i = 0; i < 10; i++) begin
            step(100 + i, RT, 5'd8, 5'd0, 1, 1, 5'd8, 0, 0, 5'd0, 1'b1);
        end
        idle(110, 1'b0);
        idle(111, 1'b0);

        repeat (3) @(posedge clk);
        check("queue drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/di_hazard_stall_unit.md
DI_HAZARD_STALL_UNIT -- requirements
Module: di_hazard_stall_unit

Interface
REQ-001 SHALL have parameter BEQ_OP, default 6'b000100: branch-equal opcode, resolved in decode.
REQ-002 SHALL have parameter LW_OP, default 6'b100011: load-word opcode.
REQ-003 SHALL have parameter SW_OP, default 6'b101011: store-word opcode.
REQ-004 SHALL have parameter RTYPE_OP, default 6'b000000: R-type opcode.
REQ-005 SHALL have parameter CNT_W, default 16: stall-statistics counter width.
REQ-006 SHALL have the following ports; the single clock is clk, and reset is reset, asynchronous and active-high:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  IFIDopcode  in  6  decode-stage opcode
  IFIDrs  in  5  decode-stage rs
  IFIDrt  in  5  decode-stage rt
  IDEXregwrite  in  1  EX-stage instruction writes register file
  IDEXmemread  in  1  EX-stage instruction is a load
  IDEXWriteReg  in  5  EX-stage destination register
  EXMEregwrite  in  1  MEM-stage instruction writes register file
  EXMEmemtoreg  in  1  MEM-stage instruction is a load
  EXMEWriteReg  in  5  MEM-stage destination register
  pcWrite  out  1  1 = PC may update
  IFIDwrite  out  1  1 = IF/ID register may load
  IDEXbubble  out  1  1 = load NOP control into ID/EX
  stallCount  out  CNT_W  total stalled cycles since reset

Function
REQ-007 SHALL treat rs as read for every opcode except 6'b000010 (j) and 6'b000011 (jal); rt as read only for RTYPE_OP, SW_OP, BEQ_OP.
REQ-008 SHALL never flag a hazard on register 0, and never match a source that is not read per REQ-007.
REQ-009 Load-use: IDEXmemread=1, IDEXregwrite=1, IDEXWriteReg matches a read source -> need 1 stall; need 2 stalls if IFIDopcode=BEQ_OP.
REQ-010 Branch-ALU: IFIDopcode=BEQ_OP, IDEXregwrite=1, IDEXmemread=0, IDEXWriteReg matches rs or rt -> need 1 stall (value then forwarded from EX/MEM by decode forwarding).
REQ-011 Branch-load-late: IFIDopcode=BEQ_OP, EXMEregwrite=1, EXMEmemtoreg=1, EXMEWriteReg matches rs or rt -> need 1 stall.
REQ-012 Multiple simultaneous conditions (including rs and rt both matching) SHALL yield the maximum need, never a sum.
REQ-013 FSM states RUN and HOLD; RUN with need=0 -> RUN; RUN with need=1 -> RUN (stall only this cycle); RUN with need=2 -> HOLD; HOLD -> RUN unconditionally.
REQ-014 Stall SHALL be asserted combinationally when (state=RUN and need>0) or state=HOLD; hazard inputs SHALL be ignored in HOLD.
REQ-015 While stall asserted: pcWrite=0, IFIDwrite=0, IDEXbubble=1; otherwise pcWrite=1, IFIDwrite=1, IDEXbubble=0.
REQ-016 stallCount SHALL increment by 1 on each rising clk edge where stall is asserted, and saturate at all-ones (no wrap).
REQ-017 Detection latency SHALL be zero cycles (same-cycle Mealy output); total stalls per hazard exactly 1 or 2.

Reset
REQ-018 On reset assertion, state SHALL become RUN and stallCount 0 immediately, without waiting for clk.
REQ-019 Reset asserted in HOLD SHALL abort the second stall; after release, outputs follow REQ-014 from RUN.

Structure
REQ-020 Opcode constants and the RUN/HOLD state encoding SHALL reside in a shared MIPS package used by control and forwarding units.
REQ-021 Source-match and need evaluation SHALL be one combinational sub-module, di_hazard_detect; FSM and counter stay in the top.

Verification
REQ-022 lw $5 in EX (IDEXmemread=1, IDEXregwrite=1, IDEXWriteReg=5), R-type rs=5 in ID -> one cycle pcWrite=0, IDEXbubble=1, stallCount 0->1.
REQ-023 Same load, beq rs=5 rt=9 in ID -> two consecutive stall cycles, state RUN->HOLD->RUN, stallCount 0->2.
REQ-024 beq rs=3 rt=3, IDEXregwrite=1, IDEXmemread=0, IDEXWriteReg=3 -> exactly one stall (no double count).
REQ-025 IDEXWriteReg=0 with load, R-type rs=0 -> no stall; j opcode with rs field=5 vs load to 5 -> no stall.
REQ-026 Assert reset asynchronously mid-HOLD -> state RUN, stallCount 0, outputs unstalled before next clk edge.
REQ-027 Force stallCount to all-ones minus 1, three stall cycles -> stallCount remains all-ones.
